// File: rtl/bios_dport_arbiter.sv
// Round-robin arbiter sharing the BIOS data read port between the core
// load path (0) and the debug/loader path (1), with per-requester response slots.
module bios_dport_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   input  logic                  rsp0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   input  logic                  rsp1_ready,
   output logic [ADDR_WIDTH-1:0] mem_adr,
   output logic                  mem_en,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  busy
);

   logic                  pend0_q, pend0_d;
   logic                  pend1_q, pend1_d;
   logic                  infl_q, infl_d;
   logic                  infl_id_q, infl_id_d;
   logic                  last_q, last_d;
   logic                  rsp0_vld_q, rsp0_vld_d;
   logic                  rsp1_vld_q, rsp1_vld_d;
   logic [DATA_WIDTH-1:0] rsp0_dat_q, rsp0_dat_d;
   logic [DATA_WIDTH-1:0] rsp1_dat_q, rsp1_dat_d;

   logic hs0, hs1, elig0, elig1, gnt0, gnt1;

   // A consumed slot can be refilled by a grant in the same cycle
   assign hs0   = rsp0_vld_q & rsp0_ready;
   assign hs1   = rsp1_vld_q & rsp1_ready;
   assign elig0 = req0_valid & (~pend0_q | hs0);
   assign elig1 = req1_valid & (~pend1_q | hs1);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         if (elig0 && elig1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = elig0;
            gnt1 = elig1;
         end
      end
   end

   always_comb begin
      req0_ready = gnt0;
      req1_ready = gnt1;
      mem_en     = gnt0 | gnt1;
      mem_adr    = '0;
      if (gnt0) mem_adr = req0_addr;
      else if (gnt1) mem_adr = req1_addr;
      rsp0_valid = rsp0_vld_q;
      rsp0_data  = rsp0_dat_q;
      rsp1_valid = rsp1_vld_q;
      rsp1_data  = rsp1_dat_q;
      busy       = infl_q | pend0_q | pend1_q;
   end

   always_comb begin
      pend0_d    = pend0_q;
      pend1_d    = pend1_q;
      infl_d     = gnt0 | gnt1;
      infl_id_d  = infl_id_q;
      last_d     = last_q;
      rsp0_vld_d = rsp0_vld_q;
      rsp1_vld_d = rsp1_vld_q;
      rsp0_dat_d = rsp0_dat_q;
      rsp1_dat_d = rsp1_dat_q;
      if (gnt0 || gnt1) begin
         infl_id_d = gnt1;
         last_d    = gnt1;
      end
      if (gnt0) pend0_d = 1'b1;
      else if (hs0) pend0_d = 1'b0;
      if (gnt1) pend1_d = 1'b1;
      else if (hs1) pend1_d = 1'b0;
      if (hs0) rsp0_vld_d = 1'b0;
      if (hs1) rsp1_vld_d = 1'b0;
      if (infl_q && !infl_id_q) begin
         rsp0_vld_d = 1'b1;
         rsp0_dat_d = mem_dout;
      end
      if (infl_q && infl_id_q) begin
         rsp1_vld_d = 1'b1;
         rsp1_dat_d = mem_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend0_q    <= 1'b0;
         pend1_q    <= 1'b0;
         infl_q     <= 1'b0;
         infl_id_q  <= 1'b0;
         last_q     <= 1'b1;
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
         rsp0_dat_q <= '0;
         rsp1_dat_q <= '0;
      end else begin
         pend0_q    <= pend0_d;
         pend1_q    <= pend1_d;
         infl_q     <= infl_d;
         infl_id_q  <= infl_id_d;
         last_q     <= last_d;
         rsp0_vld_q <= rsp0_vld_d;
         rsp1_vld_q <= rsp1_vld_d;
         rsp0_dat_q <= rsp0_dat_d;
         rsp1_dat_q <= rsp1_dat_d;
      end
   end

endmodule

// File: tb/tb_bios_dport_arbiter.sv
// Directed bench for bios_dport_arbiter with a registered BIOS memory model.
module tb_bios_dport_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic          rsp0_ready, rsp1_ready;
   logic [AW-1:0] mem_adr;
   logic          mem_en;
   logic [DW-1:0] mem_dout = '0;
   logic          busy;

   int n_pass = 0;
   int n_tot  = 0;
   logic [DW-1:0] held;

   bios_dport_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .mem_adr(mem_adr), .mem_en(mem_en),
      .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      if (a == 12'h010) return 32'hDEADBEEF;
      return {20'hC0DE0, a};
   endfunction

   always @(posedge clk)
      if (mem_en) mem_dout <= word(mem_adr);

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic drain();
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      repeat (4) nxt();
      #1;
      chk("idle", busy, 0);
   endtask

   task automatic do_reset();
      req0_valid = 0; req1_valid = 0;
      reset = 0;
      repeat (2) nxt();
      reset = 1;
   endtask

   initial begin
      reset = 0;
      req0_valid = 1; req0_addr = 12'h010;
      req1_valid = 1; req1_addr = 12'h020;
      rsp0_ready = 1; rsp1_ready = 1;
      nxt(); nxt(); #1;
      chk("rst_r0rdy", req0_ready, 0);
      chk("rst_r1rdy", req1_ready, 0);
      chk("rst_en", mem_en, 0);
      chk("rst_adr", mem_adr, 0);
      chk("rst_v0", rsp0_valid, 0);
      chk("rst_d0", rsp0_data, 0);
      chk("rst_busy", busy, 0);

      // single read
      nxt();
      reset = 1; req1_valid = 0; #1;
      chk("t1_rdy", req0_ready, 1);
      chk("t1_en", mem_en, 1);
      chk("t1_adr", mem_adr, 12'h010);
      nxt();
      req0_valid = 0; #1;
      chk("t1_v0_t1", rsp0_valid, 0);
      chk("t1_busy_t1", busy, 1);
      nxt(); #1;
      chk("t1_v0_t2", rsp0_valid, 1);
      chk("t1_d0_t2", rsp0_data, 32'hDEADBEEF);
      nxt(); #1;
      chk("t1_v0_t3", rsp0_valid, 0);
      chk("t1_busy_t3", busy, 0);

      // alternating grants
      do_reset();
      req0_valid = 1; req0_addr = 12'h004;
      req1_valid = 1; req1_addr = 12'h008;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t2_g0", req0_ready, (k % 2) == 0);
         chk("t2_g1", req1_ready, (k % 2) == 1);
         chk("t2_en", mem_en, 1);
         chk("t2_adr", mem_adr, (k % 2) ? 12'h008 : 12'h004);
         if (k >= 2) begin
            chk("t2_v0", rsp0_valid, (k % 2) == 0);
            chk("t2_v1", rsp1_valid, (k % 2) == 1);
            if (k % 2 == 0) chk("t2_d0", rsp0_data, word(12'h004));
            else chk("t2_d1", rsp1_data, word(12'h008));
         end
         nxt();
      end
      drain();

      // back-pressure on requester 1
      req1_valid = 1; req1_addr = 12'h020; rsp1_ready = 0;
      #1;
      chk("t3_g1", req1_ready, 1);
      nxt();
      req0_valid = 1; req0_addr = 12'h030; rsp0_ready = 1;
      for (int j = 1; j < 7; j++) begin
         #1;
         chk("t3_g0", req0_ready, (j % 2) == 1);
         chk("t3_r1", req1_ready, 0);
         if (j >= 2) begin
            chk("t3_v1", rsp1_valid, 1);
            chk("t3_d1", rsp1_data, word(12'h020));
         end
         nxt();
      end
      rsp1_ready = 1; #1;
      chk("t3_rel1", req1_ready, 1);
      chk("t3_rel0", req0_ready, 0);
      nxt();
      drain();

      // all-ones address
      req0_valid = 1; req0_addr = 12'hFFF; #1;
      chk("t4_adr", mem_adr, 12'hFFF);
      chk("t4_rdy", req0_ready, 1);
      nxt(); req0_valid = 0;
      nxt(); #1;
      chk("t4_v0", rsp0_valid, 1);
      chk("t4_d0", rsp0_data, word(12'hFFF));
      drain();

      // reset in the middle of a read
      req0_valid = 1; req0_addr = 12'h040; #1;
      chk("t5_g0", req0_ready, 1);
      nxt();
      reset = 0; req1_valid = 1; #1;
      chk("t5_r0", req0_ready, 0);
      chk("t5_r1", req1_ready, 0);
      chk("t5_en", mem_en, 0);
      chk("t5_adr", mem_adr, 0);
      nxt(); #1;
      chk("t5_v0", rsp0_valid, 0);
      chk("t5_busy", busy, 0);
      reset = 1; #1;
      chk("t5_tie0", req0_ready, 1);
      chk("t5_tie1", req1_ready, 0);
      nxt();
      req0_valid = 0; req1_valid = 0; #1;
      chk("t5_nodel", rsp0_valid, 0);
      drain();

      // withdrawn request while slot 1 is occupied
      req1_valid = 1; req1_addr = 12'h050; rsp1_ready = 0; #1;
      chk("t6_g1", req1_ready, 1);
      nxt(); req1_valid = 0;
      nxt(); #1;
      chk("t6_v1", rsp1_valid, 1);
      held = rsp1_data;
      chk("t6_d1", held, word(12'h050));
      req1_valid = 1; req1_addr = 12'h060; #1;
      chk("t6_nog", req1_ready, 0);
      chk("t6_noen", mem_en, 0);
      nxt();
      req1_valid = 0; #1;
      chk("t6_hold", rsp1_data, word(12'h050));
      nxt(); #1;
      chk("t6_hold2", rsp1_data, word(12'h050));
      chk("t6_v1b", rsp1_valid, 1);
      req0_valid = 1; req0_addr = 12'h070;
      req1_valid = 1; req1_addr = 12'h080; rsp1_ready = 1; #1;
      chk("t6_tie0", req0_ready, 1);
      chk("t6_tie1", req1_ready, 0);
      nxt();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
